// File: rtl/morse_rx.sv
// Morse receive FSM: converts debounced key presses into dot/dash symbol vectors,
// emitting one character per inter-character gap and a space per word gap.
module morse_rx (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       user_btn,
    input  logic       btn_to,
    input  logic       dash_to,
    input  logic       inter_to,
    input  logic       word_to,
    output logic       btn_t_res,
    output logic       dash_t_res,
    output logic       inter_t_res,
    output logic       word_t_res,
    output logic [5:0] char_data,
    output logic [2:0] char_index,
    output logic       char_valid
);

    typedef enum logic [2:0] {StIdle, StPress, StGap, StWordGap, StStuck} state_t;

    state_t     state, state_d;
    logic       dash_seen;
    logic       ovf;
    // Set when a press starts together with an emit, so the emitted data stays
    // visible during the strobe and the buffer is cleared one cycle later.
    logic       fresh;
    logic [5:0] base_data;
    logic [2:0] base_index;
    logic       base_ovf;
    logic       sym;

    always_comb begin
        base_data  = fresh ? 6'd0 : char_data;
        base_index = fresh ? 3'd0 : char_index;
        base_ovf   = fresh ? 1'b0 : ovf;
        sym        = dash_seen | dash_to;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            StIdle:    if (user_btn) state_d = StPress;
            StPress: begin
                if (btn_to)         state_d = StStuck;
                else if (!user_btn) state_d = StGap;
            end
            StGap: begin
                if (inter_to)      state_d = user_btn ? StPress : StWordGap;
                else if (user_btn) state_d = StPress;
            end
            StWordGap: begin
                if (word_to)       state_d = user_btn ? StPress : StIdle;
                else if (user_btn) state_d = StPress;
            end
            StStuck:   if (!user_btn) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            char_data   <= 6'd0;
            char_index  <= 3'd0;
            char_valid  <= 1'b0;
            dash_seen   <= 1'b0;
            ovf         <= 1'b0;
            fresh       <= 1'b0;
            btn_t_res   <= 1'b1;
            dash_t_res  <= 1'b1;
            inter_t_res <= 1'b1;
            word_t_res  <= 1'b1;
        end else begin
            state       <= state_d;
            char_valid  <= 1'b0;
            btn_t_res   <= (state_d != StPress);
            dash_t_res  <= (state_d != StPress);
            inter_t_res <= (state_d != StGap);
            word_t_res  <= (state_d != StWordGap);
            unique case (state)
                StIdle: begin
                    if (user_btn) begin
                        char_data  <= 6'd0;
                        char_index <= 3'd0;
                        ovf        <= 1'b0;
                        fresh      <= 1'b0;
                        dash_seen  <= 1'b0;
                    end
                end
                StPress: begin
                    dash_seen <= sym;
                    if (btn_to) begin
                        char_data  <= 6'd0;
                        char_index <= 3'd0;
                        ovf        <= 1'b0;
                        fresh      <= 1'b0;
                        dash_seen  <= 1'b0;
                    end else if (!user_btn) begin
                        if (base_index < 3'd6) begin
                            char_data  <= base_data | (6'(sym) << base_index);
                            char_index <= base_index + 3'd1;
                            ovf        <= base_ovf;
                        end else begin
                            ovf <= 1'b1;
                        end
                        fresh     <= 1'b0;
                        dash_seen <= 1'b0;
                    end else if (fresh) begin
                        char_data  <= 6'd0;
                        char_index <= 3'd0;
                        ovf        <= 1'b0;
                        fresh      <= 1'b0;
                    end
                end
                StGap: begin
                    if (inter_to) begin
                        char_valid <= !ovf;
                        fresh      <= user_btn;
                    end
                end
                StWordGap: begin
                    if (word_to) begin
                        char_data  <= 6'd0;
                        char_index <= 3'd0;
                        ovf        <= 1'b0;
                        char_valid <= 1'b1;
                    end else if (user_btn) begin
                        char_data  <= 6'd0;
                        char_index <= 3'd0;
                        ovf        <= 1'b0;
                    end
                end
                StStuck: begin
                    if (!user_btn) begin
                        char_data  <= 6'd0;
                        char_index <= 3'd0;
                        ovf        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_rx.sv
// Randomized bench for morse_rx: drives key/timeout sequences at the symbol level and
// checks emitted characters against a queue of characters built from the symbol lists.
module tb_morse_rx;

    logic       clk = 1'b0;
    logic       reset, user_btn, btn_to, dash_to, inter_to, word_to;
    logic       btn_t_res, dash_t_res, inter_t_res, word_t_res;
    logic [5:0] char_data;
    logic [2:0] char_index;
    logic       char_valid;

    morse_rx dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .user_btn   (user_btn),
        .btn_to     (btn_to),
        .dash_to    (dash_to),
        .inter_to   (inter_to),
        .word_to    (word_to),
        .btn_t_res  (btn_t_res),
        .dash_t_res (dash_t_res),
        .inter_t_res(inter_t_res),
        .word_t_res (word_t_res),
        .char_data  (char_data),
        .char_index (char_index),
        .char_valid (char_valid)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];   // {index, data} of every character the DUT owes us
    bit         cur_syms[$];  // symbols of the character being keyed, 1 = dash

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A character keeps only its first six symbols; index counts the kept ones.
    function automatic logic [8:0] pack_char();
        int         m;
        logic [5:0] d;
        m = (cur_syms.size() < 6) ? cur_syms.size() : 6;
        d = 6'd0;
        for (int k = 0; k < m; k++) d[k] = cur_syms[k];
        return {3'(m), d};
    endfunction

    always @(negedge clk) begin
        if (!reset && char_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("char_index", 32'(char_index), 32'(e[8:6]));
                check("char_data", 32'(char_data), 32'(e[5:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_tres(input string tag);
        check({tag, "_btn_t_res"}, 32'(btn_t_res), 1);
        check({tag, "_inter_t_res"}, 32'(inter_t_res), 1);
        check({tag, "_word_t_res"}, 32'(word_t_res), 1);
    endtask

    // One key press; pulse 1 = inter_to with the press edge, 2 = word_to with it.
    task automatic press(input bit dash, input int pulse);
        int h, dpos;
        if (pulse == 1) begin
            if (cur_syms.size() <= 6) exp_q.push_back(pack_char());
            cur_syms.delete();
            inter_to = 1'b1;
        end
        if (pulse == 2) begin
            exp_q.push_back(9'd0);
            word_to = 1'b1;
        end
        user_btn = 1'b1;
        step();
        inter_to = 1'b0;
        word_to  = 1'b0;
        check("press_btn_t_res", 32'(btn_t_res), 0);
        check("press_dash_t_res", 32'(dash_t_res), 0);
        check("press_inter_t_res", 32'(inter_t_res), 1);
        h    = $urandom_range(1, 4);
        dpos = $urandom_range(0, h);
        for (int i = 0; i < h; i++) begin
            dash_to = dash && (i == dpos);
            step();
        end
        user_btn = 1'b0;
        dash_to  = dash && (dpos == h);
        step();
        dash_to = 1'b0;
        cur_syms.push_back(dash);
        check("gap_inter_t_res", 32'(inter_t_res), 0);
        check("gap_btn_t_res", 32'(btn_t_res), 1);
        repeat ($urandom_range(0, 3)) step();
    endtask

    // Called in the gap after a character: inter_to, then optionally word_to.
    task automatic end_char(input bit word);
        logic [8:0] held;
        held = pack_char();
        if (cur_syms.size() <= 6) exp_q.push_back(held);
        cur_syms.delete();
        inter_to = 1'b1;
        step();
        inter_to = 1'b0;
        step();
        check("wgap_word_t_res", 32'(word_t_res), 0);
        check("hold_index", 32'(char_index), 32'(held[8:6]));
        check("hold_data", 32'(char_data), 32'(held[5:0]));
        if (word) begin
            repeat ($urandom_range(0, 2)) step();
            exp_q.push_back(9'd0);
            word_to = 1'b1;
            step();
            word_to = 1'b0;
            check_idle_tres("idle");
            check("space_index", 32'(char_index), 0);
        end
    endtask

    // A press held until btn_to; the partial character is thrown away.
    task automatic stuck_press();
        user_btn = 1'b1;
        step();
        repeat ($urandom_range(0, 2)) step();
        btn_to = 1'b1;
        step();
        btn_to = 1'b0;
        check_idle_tres("stuck");
        inter_to = 1'b1;
        step();
        inter_to = 1'b0;
        user_btn = 1'b0;
        step();
        cur_syms.delete();
        check_idle_tres("stuck_idle");
        check("stuck_index", 32'(char_index), 0);
        inter_to = 1'b1;
        step();
        inter_to = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pend, n;
        reset    = 1'b1;
        user_btn = 1'b0;
        btn_to   = 1'b0;
        dash_to  = 1'b0;
        inter_to = 1'b0;
        word_to  = 1'b0;
        #12;
        check_idle_tres("reset");
        check("reset_dash_t_res", 32'(dash_t_res), 1);
        check("reset_valid", 32'(char_valid), 0);
        check("reset_index", 32'(char_index), 0);
        check("reset_data", 32'(char_data), 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // A, C, K then a space
        press(0, 0); press(1, 0); end_char(0);
        press(1, 0); press(0, 0); press(1, 0); press(0, 0); end_char(0);
        press(1, 0); press(0, 0); press(1, 0); end_char(1);
        // stuck key, then an overflowing seven-dot character
        stuck_press();
        for (int k = 0; k < 7; k++) press(0, 0);
        end_char(1);

        pend = 0;
        for (int c = 0; c < 150; c++) begin
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 8) : $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                int p;
                p = 0;
                if (k == 0 && pend == 1) p = 1;
                else if (k == 0 && pend == 2 && $urandom_range(0, 1) == 1) p = 2;
                press(1'($urandom_range(0, 1)), p);
            end
            if ($urandom_range(0, 9) == 0) begin
                stuck_press();
                pend = 0;
            end else begin
                case ($urandom_range(0, 2))
                    0: begin end_char(1); pend = 0; end
                    1: begin end_char(0); pend = 2; end
                    default: pend = 1;
                endcase
            end
        end
        if (pend == 1) end_char(1);

        // reset in the middle of a press aborts the character
        press(1, 0);
        user_btn = 1'b1;
        step();
        #2;
        reset = 1'b1;
        #1;
        check_idle_tres("midrst");
        check("midrst_valid", 32'(char_valid), 0);
        check("midrst_index", 32'(char_index), 0);
        check("midrst_data", 32'(char_data), 0);
        cur_syms.delete();
        user_btn = 1'b0;
        step();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        check("pending_expected", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
